// File: rtl/ysyx_25040111_pkg.sv
// Shared types and sizes for the writeback unit and its scoreboard.
// Optional feature macro used by the top level: YSYX_25040111_WBU_PERF_EN.
package ysyx_25040111_pkg;

  localparam int XLEN   = 32;
  localparam int NR_REG = 16;
  localparam int AW     = 4;

  typedef enum logic {
    SRC_EXU = 1'b0,
    SRC_LSU = 1'b1
  } src_e;

  typedef struct packed {
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } wb_req_t;

  // A register reads as busy only while its write has not reached the RF port.
  function automatic logic busy_lookup(
    input logic [NR_REG-1:0] sb,
    input logic [AW-1:0]     a,
    input logic              fwd_en,
    input logic [AW-1:0]     fwd_addr
  );
    return (a != '0) && sb[a] && !(fwd_en && (fwd_addr == a));
  endfunction

endpackage

// File: rtl/ysyx_25040111_scoreboard.sv
// Pending-write scoreboard with forward-masked busy lookups.
// Set wins over clear on the same register; entry 0 never holds a bit.
module ysyx_25040111_scoreboard
  import ysyx_25040111_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              set_en,
  input  logic [AW-1:0]     set_addr,
  input  logic              clr_en,
  input  logic [AW-1:0]     clr_addr,
  input  logic [AW-1:0]     ars1,
  input  logic [AW-1:0]     ars2,
  input  logic [1:0]        ren,
  input  logic [AW-1:0]     qrd,
  output logic              rs1_busy,
  output logic              rs2_busy,
  output logic              rd_busy,
  output logic [NR_REG-1:0] sb
);

  logic [NR_REG-1:0] sb_q;
  logic [NR_REG-1:0] sb_d;

  always_comb begin
    sb_d = sb_q;
    if (clr_en) sb_d[clr_addr] = 1'b0;
    if (set_en) sb_d[set_addr] = 1'b1;
    sb_d[0] = 1'b0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) sb_q <= '0;
    else          sb_q <= sb_d;
  end

  always_comb begin
    rs1_busy = ren[0] && busy_lookup(sb_q, ars1, clr_en, clr_addr);
    rs2_busy = ren[1] && busy_lookup(sb_q, ars2, clr_en, clr_addr);
    rd_busy  = busy_lookup(sb_q, qrd, clr_en, clr_addr);
  end

  assign sb = sb_q;

endmodule

// File: rtl/ysyx_25040111_wbu.sv
// Writeback unit: round-robin EXU/LSU arbiter, one-cycle RF write stage.
// Define YSYX_25040111_WBU_PERF_EN to add the writeback/conflict counters.
module ysyx_25040111_wbu
  import ysyx_25040111_pkg::*;
(
  input  logic            clock,
  input  logic            reset_n,
  input  logic            iss_valid,
  input  logic [AW-1:0]   iss_rd,
  input  logic            exu_valid,
  output logic            exu_ready,
  input  logic [AW-1:0]   exu_rd,
  input  logic [XLEN-1:0] exu_data,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [AW-1:0]   lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  input  logic [AW-1:0]   dec_ars1,
  input  logic [AW-1:0]   dec_ars2,
  input  logic [1:0]      dec_ren,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic            rd_busy,
`ifdef YSYX_25040111_WBU_PERF_EN
  output logic [31:0]     perf_wb_cnt,
  output logic [31:0]     perf_conflict_cnt,
`endif
  output logic            rf_wen,
  output logic [AW-1:0]   rf_waddr,
  output logic [XLEN-1:0] rf_wdata
);

  src_e            last_q, last_d;
  logic            rf_wen_q, rf_wen_d;
  logic [AW-1:0]   rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;

  logic            both;
  logic            gnt_lsu;
  logic            gnt_exu;
  wb_req_t         sel;
  logic            acc;
  logic [NR_REG-1:0] sb;

  // Ready is a pure grant: the RF port never back-pressures.
  always_comb begin
    both    = exu_valid && lsu_valid;
    gnt_lsu = lsu_valid && (!exu_valid || (last_q == SRC_EXU));
    gnt_exu = exu_valid && !gnt_lsu;
    acc     = gnt_lsu || gnt_exu;
    last_d  = last_q;
    if (both) last_d = gnt_lsu ? SRC_LSU : SRC_EXU;
  end

  always_comb begin
    sel = '{rd: rf_waddr_q, data: rf_wdata_q};
    unique case (1'b1)
      gnt_lsu: sel = '{rd: lsu_rd, data: lsu_data};
      gnt_exu: sel = '{rd: exu_rd, data: exu_data};
      default: ;
    endcase
  end

  always_comb begin
    rf_wen_d   = acc && (sel.rd != '0);
    rf_waddr_d = sel.rd;
    rf_wdata_d = sel.data;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_q     <= SRC_EXU;
      rf_wen_q   <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      last_q     <= last_d;
      rf_wen_q   <= rf_wen_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign exu_ready = gnt_exu;
  assign lsu_ready = gnt_lsu;
  assign rf_wen    = rf_wen_q;
  assign rf_waddr  = rf_waddr_q;
  assign rf_wdata  = rf_wdata_q;

  ysyx_25040111_scoreboard u_sb (
    .clock    (clock),
    .reset_n  (reset_n),
    .set_en   (iss_valid && (iss_rd != '0)),
    .set_addr (iss_rd),
    .clr_en   (rf_wen_q),
    .clr_addr (rf_waddr_q),
    .ars1     (dec_ars1),
    .ars2     (dec_ars2),
    .ren      (dec_ren),
    .qrd      (iss_rd),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy),
    .rd_busy  (rd_busy),
    .sb       (sb)
  );

`ifdef YSYX_25040111_WBU_PERF_EN
  logic [31:0] wb_cnt_q, wb_cnt_d;
  logic [31:0] cf_cnt_q, cf_cnt_d;

  always_comb begin
    wb_cnt_d = wb_cnt_q + {31'd0, rf_wen_q};
    cf_cnt_d = cf_cnt_q + {31'd0, both};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wb_cnt_q <= '0;
      cf_cnt_q <= '0;
    end else begin
      wb_cnt_q <= wb_cnt_d;
      cf_cnt_q <= cf_cnt_d;
    end
  end

  assign perf_wb_cnt       = wb_cnt_q;
  assign perf_conflict_cnt = cf_cnt_q;
`endif

  a_no_waw_issue: assert property (
    @(posedge clock) disable iff (!reset_n)
    !(iss_valid && rd_busy));

  a_exu_rd_pending: assert property (
    @(posedge clock) disable iff (!reset_n)
    (exu_valid && (exu_rd != '0)) |-> sb[exu_rd]);

  a_lsu_rd_pending: assert property (
    @(posedge clock) disable iff (!reset_n)
    (lsu_valid && (lsu_rd != '0)) |-> sb[lsu_rd]);

  a_exu_stable: assert property (
    @(posedge clock) disable iff (!reset_n)
    (exu_valid && !exu_ready) |=>
      (exu_valid && $stable(exu_rd) && $stable(exu_data)));

  a_lsu_stable: assert property (
    @(posedge clock) disable iff (!reset_n)
    (lsu_valid && !lsu_ready) |=>
      (lsu_valid && $stable(lsu_rd) && $stable(lsu_data)));

endmodule

// File: doc/ysyx_25040111_wbu.md
Name: ysyx_25040111_wbu

Overview:
Writeback unit that drives the single write port of the 16-entry, 32-bit integer register file. It arbitrates register results from the EXU (ALU/CSR) and the LSU (loads), each on a valid/ready handshake. It tracks pending destination registers in a scoreboard so that decode stalls on RAW and WAW hazards. It sits between the execute/memory stages and the register file, and also feeds the busy flags back to decode.

Parameters:
XLEN, 32, data width of results and of the register file
NR_REG, 16, number of architectural registers (RV32E)
AW, 4, register address width, log2(NR_REG)

Ports:
clock  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
iss_valid  input  1  decode issues an instruction that writes rd this cycle
iss_rd  input  AW  destination of the issued instruction
exu_valid  input  1  EXU result available
exu_ready  output  1  EXU result accepted this cycle
exu_rd  input  AW  EXU destination
exu_data  input  XLEN  EXU result
lsu_valid  input  1  LSU load result available
lsu_ready  output  1  LSU result accepted this cycle
lsu_rd  input  AW  LSU destination
lsu_data  input  XLEN  LSU result
dec_ars1  input  AW  decode source 1 address
dec_ars2  input  AW  decode source 2 address
dec_ren  input  2  decode read enables, bit0 = rs1, bit1 = rs2
rs1_busy  output  1  rs1 has a pending write, so decode must stall
rs2_busy  output  1  rs2 has a pending write, so decode must stall
rd_busy  output  1  iss_rd has a pending write (WAW), so decode must not issue
rf_wen  output  1  register file write enable
rf_waddr  output  AW  register file write address
rf_wdata  output  XLEN  register file write data

Behaviour:
- Reset (asynchronous on reset_n low): rf_wen=0, rf_waddr=0, rf_wdata=0, scoreboard all zeros, round-robin pointer = EXU-last (so LSU wins the first conflict). Combinational outputs follow from these: exu_ready/lsu_ready follow valid, all busy flags are 0. Reset mid-transfer discards every in-flight result.
- Acceptance: a transfer completes when valid && ready at a rising edge. Ready is a pure grant, with no dependence on the downstream side, because the register file always accepts.
- Arbitration:
  - Only one source valid: that source is granted.
  - Both sources valid: the source not granted last time is granted.
  - The pointer updates only on a conflict grant.
- Output stage: the granted rd/data are registered into rf_waddr/rf_wdata, and rf_wen=1 in the next cycle (latency 1). rf_wen is held for exactly one cycle per accepted result.
- rd == 0: the result is accepted (ready asserted normally), but rf_wen stays 0 and the scoreboard is untouched.
- Scoreboard: NR_REG bits, bit 0 hardwired to 0.
  - Set on iss_valid && iss_rd != 0.
  - Cleared at the edge where rf_wen && rf_waddr matches.
  - Set and clear on the same register in the same cycle: set wins.
- Busy flags:
  - rsN_busy = dec_ren[N] && sb[ars] && !(rf_wen && rf_waddr == ars). The masking term matches the register file's same-cycle write forwarding.
  - rd_busy uses the same expression with iss_rd and no ren gating.
  - Every busy flag is 0 for address 0.
- Protocol rules, checked by assertions in simulation:
  - iss_valid with rd_busy=1 is illegal.
  - A result whose rd has a clear scoreboard bit is illegal.
  - valid must not drop, and rd/data must not change, until ready.

Optional Feature:
YSYX_25040111_WBU_PERF_EN
- Defined: adds two 32-bit outputs, perf_wb_cnt (counts rf_wen cycles) and perf_conflict_cnt (counts cycles with both sources valid). Both reset to 0 and wrap modulo 2^32.
- Undefined: the ports and counters are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package ysyx_25040111_pkg: XLEN, NR_REG, AW, and the source-select encoding (SRC_EXU=0, SRC_LSU=1).
- One sub-module, ysyx_25040111_scoreboard: holds the NR_REG-bit set/clear vector and the three forward-masked busy lookups.
- The arbiter and output register stay in the top level.

Test Plan:
- Reset, then iss rd=5, then exu_valid rd=5 data=0xDEADBEEF. Expect: rs1_busy=1 for ars1=5 until the write cycle. rf_wen=1, rf_waddr=5, rf_wdata=0xDEADBEEF one cycle after acceptance. rs1_busy=0 during the write cycle.
- exu (rd=3, 0x11) and lsu (rd=4, 0x22) valid together. Expect: cycle 0 lsu_ready=1, exu_ready=0. Cycle 1 exu_ready=1. Writes in order x4=0x22, then x3=0x11.
- Sustained conflict over 6 cycles. Expect grants to alternate LSU, EXU, LSU, EXU, LSU, EXU with no bubbles on rf_wen.
- exu_valid rd=0 data=0x5. Expect: exu_ready=1, rf_wen stays 0. rs1_busy=0 with ars1=0 and dec_ren=2'b11.
- Same cycle: rf_wen writes x7 and iss_valid rd=7. Expect the scoreboard bit for x7 to remain 1 afterwards, so rd_busy=1 next cycle.
- Drop reset_n with a result latched in the output stage. Expect: rf_wen=0 immediately, all busy flags 0, no write after release.
